// File: rtl/char_buffer_arbiter_if.sv
// Handshake and display bus between the character buffer arbiter and its
// neighbours: two valid/ready requesters, the clear pulse, the VGA vertical
// sync input and the committed display buffer with its status flags.
interface char_buffer_arbiter_if #(
    parameter int MAX_INPUT = 60
);
    logic                 key_valid;
    logic [3:0]           key_code;
    logic                 key_ready;
    logic                 res_valid;
    logic [3:0]           res_code;
    logic                 res_ready;
    logic                 clear_req;
    logic                 vga_v_sync;
    logic [MAX_INPUT-1:0] numbers;
    logic                 busy;
    logic                 full;

    // Requesters, clear source and VGA timing side.
    modport master (
        output key_valid, key_code, res_valid, res_code, clear_req, vga_v_sync,
        input  key_ready, res_ready, numbers, busy, full
    );

    // The arbiter itself.
    modport slave (
        input  key_valid, key_code, res_valid, res_code, clear_req, vga_v_sync,
        output key_ready, res_ready, numbers, busy, full
    );
endinterface

// File: rtl/char_buffer_arbiter.sv
// Character buffer arbiter: two requesters (keypad echo and ALU result) share
// one write port into a shadow buffer, filled from a cursor. The shadow is
// copied to the display buffer on every falling edge of vertical sync so a
// frame never shows a half-written line. A clear request blanks the shadow
// one slot per cycle and returns the cursor to slot 0.
module char_buffer_arbiter #(
    parameter int         MAX_INPUT = 60,
    parameter logic [3:0] BLANK     = 4'hF
) (
    input logic                  clk,
    input logic                  rst_n,
    char_buffer_arbiter_if.slave bus
);
    localparam int NCHARS = MAX_INPUT / 4;
    localparam int CW     = $clog2(NCHARS + 1);

    typedef enum logic { IDLE, CLEAR } state_t;
    typedef enum logic { PRIO_KEY, PRIO_RES } prio_t;

    state_t               state;
    prio_t                prio;
    logic [CW-1:0]        cursor;
    logic [CW-1:0]        clr_idx;
    logic [MAX_INPUT-1:0] shadow;
    logic [MAX_INPUT-1:0] numbers_q;
    logic                 busy_q;
    logic                 full_q;
    logic                 vs_q;

    logic                 can_acc;
    logic                 key_grant;
    logic                 res_grant;
    logic                 wr_en;
    logic [3:0]           wr_code;
    logic                 vs_fall;

    // Grant logic: alternate between requesters when both are waiting,
    // otherwise serve whichever one is valid. Readies are forced low in reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        can_acc   = 1'b0;
        key_grant = 1'b0;
        res_grant = 1'b0;
        wr_en     = 1'b0;
        wr_code   = BLANK;
        can_acc   = rst_n && (state == IDLE) && !bus.clear_req && !full_q;
        key_grant = can_acc && bus.key_valid && (!bus.res_valid || prio == PRIO_KEY);
        res_grant = can_acc && bus.res_valid && (!bus.key_valid || prio == PRIO_RES);
        wr_en     = key_grant || res_grant;
        if (key_grant) begin
            wr_code = bus.key_code;
        end else if (res_grant) begin
            wr_code = bus.res_code;
        end
    end

    assign vs_fall       = vs_q && !bus.vga_v_sync;
    assign bus.key_ready = key_grant;
    assign bus.res_ready = res_grant;
    assign bus.numbers   = numbers_q;
    assign bus.busy      = busy_q;
    assign bus.full      = full_q;

    // Control FSM: accept writes and advance the cursor in IDLE, sweep BLANK
    // across every slot in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state   <= IDLE;
            prio    <= PRIO_KEY;
            cursor  <= '0;
            clr_idx <= '0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clear_req) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                        cursor  <= '0;
                        busy_q  <= 1'b1;
                        full_q  <= 1'b0;
                    end else if (wr_en) begin
                        cursor <= cursor + 1'b1;
                        full_q <= (cursor == CW'(NCHARS - 1));
                        prio   <= key_grant ? PRIO_RES : PRIO_KEY;
                    end
                end
                CLEAR: begin
                    if (clr_idx == CW'(NCHARS - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Shadow buffer: accepted codes land at the cursor slot, CLEAR blanks the
    // slot under clr_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this buffer is reset on purpose - the display must come up blank, not with random codes.
            shadow <= {NCHARS{BLANK}};
        end else begin
            for (int i = 0; i < NCHARS; i++) begin
                if (state == CLEAR && clr_idx == CW'(i)) begin
                    shadow[4*i +: 4] <= BLANK;
                end else if (wr_en && cursor == CW'(i)) begin
                    shadow[4*i +: 4] <= wr_code;
                end
            end
        end
    end

    // Display commit: copy the whole shadow on the vertical sync falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= 1'b1;
            numbers_q <= {NCHARS{BLANK}};
        end else begin
            vs_q <= bus.vga_v_sync;
            if (vs_fall) begin
                numbers_q <= shadow;
            end
        end
    end
endmodule
